ib_fifo_pressure: RTL
=====================

// Module: ib_fifo_pressure
// PURPOSE
//  Input buffer stage for one router input port; sits directly upstream of the route-compute stage.
//  Queues 40-bit flits arriving from the link in a DEPTH-entry FIFO and presents the head flit with valid.
//  Pops the head flit when the route-compute stage is ready.
//  Exports its registered occupancy as the port pressure used by neighbouring route-compute stages.
// PARAMETERS
//  DEPTH     8   FIFO entries; must equal 2**WIDTH.
//  WIDTH     3   pointer width; pressure/count width is WIDTH+1.
//  DATASIZE  40  flit width (src[39:36], dst[35:32], timestamp, data, type[1:0]).
// PORTS
//  rc_clk         in   1           clock
//  rst_n          in   1           reset, asynchronous, active-low
//  link_data_in   in   DATASIZE    flit from the upstream link
//  link_valid_in  in   1           link_data_in holds a flit this cycle
//  link_ready_out out  1           buffer accepts a flit this cycle (= !full)
//  data_out       out  DATASIZE    head flit to route-compute (show-ahead)
//  valid_out      out  1           data_out is a real flit (= !empty)
//  rc_ready       in   1           route-compute consumes the head this cycle
//  pressure_out   out  WIDTH+1     occupancy 0..DEPTH, registered
//  peak_pressure  out  WIDTH+1     highest occupancy since reset
//  overflow_err   out  1           sticky: a push was attempted while full
// BEHAVIOUR
//  Reset (async): rd_ptr=wr_ptr=0, count=0, data_out=0, valid_out=0, link_ready_out=1,
//   pressure_out=0, peak_pressure=0, overflow_err=0. Storage array is not reset.
//  push = link_valid_in & !full. pop = rc_ready & !empty. full = (count==DEPTH), empty = (count==0).
//  All state updates on posedge rc_clk. Pointers are WIDTH bits wide and wrap DEPTH-1 -> 0 by natural overflow.
//  count: push&!pop -> +1; pop&!push -> -1; both or neither -> unchanged. pressure_out = count.
//  data_out = mem[rd_ptr] when !empty, else 0. Data is combinational from registered state only.
//   No combinational path from rc_ready or link_valid_in to any output.
//  No bypass: a flit pushed into an empty buffer appears on data_out one cycle later.
//   Write-to-head latency is 1 cycle.
//  link_ready_out = !full, computed from registered count. A push while full is not accepted
//   even if pop happens in the same cycle; the upstream retries on the next cycle.
//  Full with link_valid_in=1: flit dropped, overflow_err set to 1 and held until reset.
//   Storage, pointers and count are unchanged.
//  Empty with rc_ready=1: no pop, no change. valid_out stays 0, so route-compute loads direction 1111.
//  Simultaneous push and pop at an intermediate occupancy: both proceed and count is unchanged.
//   With count==1, the popped entry is the old head; the new flit becomes the head next cycle.
//  peak_pressure updates to next count whenever next count > peak_pressure. Saturates at DEPTH.
//  Reset asserted mid-operation discards all buffered flits immediately.
//   Pointers and flags return to their reset values asynchronously.
// STRUCTURE
//  Shared package noc_pkg: DATASIZE, flit field slices (DST_MSB=35, DST_LSB=32, SRC 39:36),
//   direction encodings (N=4'b0100, E=4'b0010, W=4'b1000, LOCAL=4'b0000, NONE=4'b1111).
//  One natural sub-module: ib_fifo_mem, a DEPTH x DATASIZE register array with one write port
//   and an async read port. Pointer/count/flag control stays in ib_fifo_pressure.
// TESTING
//  1 Reset: rst_n low mid-stream with 5 flits buffered -> immediately valid_out=0, pressure_out=0,
//    link_ready_out=1, overflow_err=0.
//  2 Fill/drain: 8 pushes 0xA0..0xA7 with rc_ready=0 -> pressure 1..8, link_ready_out=0 at 8.
//    Then rc_ready=1 -> data_out A0..A7 in order, pressure 8..0, valid_out=0 after the last.
//  3 Overflow: full, push 0xFF with rc_ready=0 -> flit dropped, overflow_err=1 (sticky), pressure stays 8.
//    Then drain -> 0xFF never appears on data_out.
//  4 Simultaneous: count=4, push and pop for 20 cycles -> pressure_out constant 4.
//    Flits leave in push order across pointer wrap.
//  5 Empty push+pop: count=0, push 0x55 with rc_ready=1 -> no pop that cycle.
//    Next cycle valid_out=1 and data_out=0x55, pressure=1.
//  6 Peak: ramp occupancy to 6, drain to 0 -> peak_pressure=6. Then refill to 3 -> peak_pressure stays 6.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit geometry, header field positions and direction codes
// used by the router input buffer and route-compute stages.
package noc_pkg;

   localparam int DATASIZE = 40;

   // Header field positions inside a flit.
   localparam int SRC_MSB  = 39;
   localparam int SRC_LSB  = 36;
   localparam int DST_MSB  = 35;
   localparam int DST_LSB  = 32;
   localparam int TYPE_MSB = 1;
   localparam int TYPE_LSB = 0;

   typedef logic [DATASIZE-1:0] flit_t;

   typedef enum logic [3:0] {
      DIR_LOCAL = 4'b0000,
      DIR_E     = 4'b0010,
      DIR_N     = 4'b0100,
      DIR_W     = 4'b1000,
      DIR_NONE  = 4'b1111
   } dir_e;

   function automatic logic [3:0] flit_dst(input flit_t f);
      return f[DST_MSB:DST_LSB];
   endfunction

   function automatic logic [3:0] flit_src(input flit_t f);
      return f[SRC_MSB:SRC_LSB];
   endfunction

endpackage

// File: rtl/ib_fifo_mem.sv
// DEPTH x DATASIZE register array: one synchronous write port, one asynchronous read port.
module ib_fifo_mem
   import noc_pkg::*;
#(
   parameter int DEPTH    = 8,
   parameter int WIDTH    = 3,
   parameter int DATASIZE = noc_pkg::DATASIZE
) (
   input  logic                rc_clk,
   input  logic                i_wr_en,
   input  logic [WIDTH-1:0]    i_wr_addr,
   input  logic [DATASIZE-1:0] i_wr_data,
   input  logic [WIDTH-1:0]    i_rd_addr,
   output logic [DATASIZE-1:0] o_rd_data
);

   logic [DATASIZE-1:0] r_mem [DEPTH];

   // NOTE: storage has no reset; validity is tracked by the pointers/count, so
   // resetting the array would only add a reset net to every bit for nothing.
   always_ff @(posedge rc_clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/ib_fifo_pressure.sv
// Router input buffer: show-ahead FIFO feeding route-compute, exporting registered
// occupancy (pressure), its high-water mark, and a sticky overflow flag.
module ib_fifo_pressure
   import noc_pkg::*;
#(
   parameter int DEPTH    = 8,
   parameter int WIDTH    = 3,
   parameter int DATASIZE = noc_pkg::DATASIZE
) (
   input  logic                rc_clk,
   input  logic                rst_n,
   input  logic [DATASIZE-1:0] link_data_in,
   input  logic                link_valid_in,
   output logic                link_ready_out,
   output logic [DATASIZE-1:0] data_out,
   output logic                valid_out,
   input  logic                rc_ready,
   output logic [WIDTH:0]      pressure_out,
   output logic [WIDTH:0]      peak_pressure,
   output logic                overflow_err
);

   localparam int CNT_W = WIDTH + 1;

   logic [WIDTH-1:0]    r_wr_ptr;
   logic [WIDTH-1:0]    r_rd_ptr;
   logic [CNT_W-1:0]    r_count;
   logic [CNT_W-1:0]    r_peak;
   logic                r_overflow;

   logic                w_full;
   logic                w_empty;
   logic                w_push;
   logic                w_pop;
   logic [CNT_W-1:0]    w_count_nxt;
   logic [DATASIZE-1:0] w_rd_data;

   // Flags come from registered count only, so no input reaches an output combinationally.
   assign w_full  = (r_count == CNT_W'(DEPTH));
   assign w_empty = (r_count == '0);
   assign w_push  = link_valid_in & ~w_full;
   assign w_pop   = rc_ready & ~w_empty;

   // NOTE: combinational logic uses blocking assignments with a default first,
   // so every path assigns the output and no latch is inferred.
   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_pop) begin
         w_count_nxt = r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
         w_count_nxt = r_count - CNT_W'(1);
      end
   end

   ib_fifo_mem #(
      .DEPTH    (DEPTH),
      .WIDTH    (WIDTH),
      .DATASIZE (DATASIZE)
   ) u_mem (
      .rc_clk    (rc_clk),
      .i_wr_en   (w_push),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (link_data_in),
      .i_rd_addr (r_rd_ptr),
      .o_rd_data (w_rd_data)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge rc_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + WIDTH'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + WIDTH'(1);
         end
         r_count <= w_count_nxt;
      end
   end

   // High-water mark and sticky overflow, both cleared only by reset.
   always_ff @(posedge rc_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_peak     <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_count_nxt > r_peak) begin
            r_peak <= w_count_nxt;
         end
         if (link_valid_in && w_full) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign link_ready_out = ~w_full;
   assign valid_out      = ~w_empty;
   assign data_out       = w_empty ? '0 : w_rd_data;
   assign pressure_out   = r_count;
   assign peak_pressure  = r_peak;
   assign overflow_err   = r_overflow;

   // Pointer distance must always agree with the occupancy counter.
   a_count_range: assert property (@(posedge rc_clk) disable iff (!rst_n)
      r_count <= CNT_W'(DEPTH));

   a_ptr_count: assert property (@(posedge rc_clk) disable iff (!rst_n)
      (w_full || (r_wr_ptr - r_rd_ptr) == r_count[WIDTH-1:0]));

   a_full_ptrs: assert property (@(posedge rc_clk) disable iff (!rst_n)
      (!w_full || r_wr_ptr == r_rd_ptr));

   a_peak_bound: assert property (@(posedge rc_clk) disable iff (!rst_n)
      (r_peak >= r_count && r_peak <= CNT_W'(DEPTH)));

endmodule
